// File: rtl/rv32i_types.sv
// Shared RV32I back-end types: CDB packet layout and sizing constants.
package rv32i_types;

  localparam int XLEN            = 32;
  localparam int ARCH_REG_IDX    = 4;   // 32 architectural registers
  localparam int PHYS_REG_IDX    = 5;   // 64 physical registers
  localparam int NUM_ROB_ENTRIES = 16;
  localparam int ROB_IDX_W       = $clog2(NUM_ROB_ENTRIES);
  localparam int NUM_FU_CDB      = 4;   // ALU, MUL, DIV, LSU

  // Result packet broadcast on the common data bus
  typedef struct packed {
    logic [XLEN-1:0]         value;
    logic [ARCH_REG_IDX:0]   rd;
    logic [PHYS_REG_IDX:0]   pd;
    logic [ROB_IDX_W-1:0]    rob_idx;
    logic                    dest_we;
    logic                    br_taken;
    logic [31:0]             br_target;
    logic                    is_ctrl;
    logic                    is_branch;
    logic                    is_jalr;
  } cdb_pkt_t;

endpackage

// File: rtl/cdb_arbiter_chk.sv
// Protocol checks for the CDB arbiter; no functional logic.
module cdb_arbiter_chk #(
  parameter int NUM_FU   = 4,
  parameter int XLEN     = 32,
  parameter int PKT_XLEN = 32
) (
  input logic              clk,
  input logic              rst_n,
  input logic              flush,
  input logic [NUM_FU-1:0] fu_valid,
  input logic [NUM_FU-1:0] fu_ready,
  input logic              cdb_valid
);

  a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(fu_ready));

  a_ready_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
    (fu_ready & ~fu_valid) == '0);

  a_no_cdb_after_flush: assert property (@(posedge clk) disable iff (!rst_n)
    flush |=> !cdb_valid);

  a_xlen_matches_pkt: assert property (@(posedge clk) disable iff (!rst_n)
    XLEN == PKT_XLEN);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic          found;
  logic [IW-1:0] cand;

  // Scan N candidates starting at ptr, wrapping modulo N (N need not be 2^k)
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (enable && !found && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
        found     = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin selects one FU result per cycle and registers it
// onto the common data bus. Grant is combinational; broadcast is registered.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_FU = NUM_FU_CDB,
  parameter int XLEN   = rv32i_types::XLEN
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic [NUM_FU-1:0]                fu_valid,
  output logic [NUM_FU-1:0]                fu_ready,
  input  cdb_pkt_t [NUM_FU-1:0]            fu_pkt,
  output logic                             cdb_valid,
  output cdb_pkt_t                         cdb_pkt,
  output logic [$clog2(NUM_FU)-1:0]        cdb_src
);

  localparam int IDX_W = $clog2(NUM_FU);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FU - 1);

  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  cdb_pkt_t          cdb_pkt_q, cdb_pkt_d;
  logic [IDX_W-1:0]  cdb_src_q, cdb_src_d;

  logic [NUM_FU-1:0] gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              arb_en;

  // Flush and reset both suppress any dequeue from the FUs
  assign arb_en = ~flush & rst_n;

  rr_arbiter #(
    .N  (NUM_FU),
    .IW (IDX_W)
  ) u_rr (
    .req     (fu_valid),
    .ptr     (rr_ptr_q),
    .enable  (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign fu_ready  = gnt;
  assign cdb_valid = cdb_valid_q;
  assign cdb_pkt   = cdb_pkt_q;
  assign cdb_src   = cdb_src_q;

  // Capture the winner's packet and advance the pointer past it
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_pkt_d   = cdb_pkt_q;
    cdb_src_d   = cdb_src_q;
    if (|gnt) begin
      cdb_valid_d = 1'b1;
      cdb_pkt_d   = fu_pkt[gnt_idx];
      cdb_src_d   = gnt_idx;
      if (gnt_idx == IDX_LAST) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = gnt_idx + IDX_ONE;
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Broadcast and pointer registers; reset drops cdb_valid immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_pkt_q   <= '0;
      cdb_src_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_pkt_q   <= cdb_pkt_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  cdb_arbiter_chk #(
    .NUM_FU   (NUM_FU),
    .XLEN     (XLEN),
    .PKT_XLEN ($bits(cdb_pkt_q.value))
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .fu_valid  (fu_valid),
    .fu_ready  (fu_ready),
    .cdb_valid (cdb_valid_q)
  );

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed table, corner sequences and
// randomized traffic against a behavioural round-robin model.
module tb_cdb_arbiter;
  import rv32i_types::*;

  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic           flush;
  logic [N-1:0]   fu_valid;
  logic [N-1:0]   fu_ready;
  cdb_pkt_t [N-1:0] fu_pkt;
  logic           cdb_valid;
  cdb_pkt_t       cdb_pkt;
  logic [1:0]     cdb_src;

  cdb_arbiter #(.NUM_FU(N), .XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .fu_valid  (fu_valid),
    .fu_ready  (fu_ready),
    .fu_pkt    (fu_pkt),
    .cdb_valid (cdb_valid),
    .cdb_pkt   (cdb_pkt),
    .cdb_src   (cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int       m_ptr;
  logic     m_valid;
  cdb_pkt_t m_pkt;
  logic [1:0] m_src;

  typedef struct packed {
    logic [3:0] valid;
    logic       flush;
    logic [3:0] ready;
    logic       cvalid;
    logic [1:0] src;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic cdb_pkt_t rand_pkt();
    cdb_pkt_t p;
    p.value     = $urandom;
    p.rd        = 5'($urandom);
    p.pd        = 6'($urandom);
    p.rob_idx   = 4'($urandom);
    p.dest_we   = 1'($urandom);
    p.br_taken  = 1'($urandom);
    p.br_target = $urandom;
    p.is_ctrl   = 1'($urandom);
    p.is_branch = 1'($urandom);
    p.is_jalr   = 1'($urandom);
    return p;
  endfunction

  // Round-robin rule: first valid FU scanning from the pointer, none on flush
  function automatic int model_grant(input logic [3:0] v, input logic fl);
    if (fl) return -1;
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_edge(input int g);
    if (g >= 0) begin
      m_valid = 1'b1;
      m_pkt   = fu_pkt[g];
      m_src   = 2'(g);
      m_ptr   = (g + 1) % N;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 1'b0;
    m_pkt   = '0;
    m_src   = 2'd0;
  endtask

  // Drive one cycle of inputs (called 1 time unit after a rising edge)
  task automatic apply(input logic [3:0] v, input logic fl, input string tag);
    int g;
    logic [3:0] er;
    fu_valid = v;
    flush    = fl;
    #1;
    g  = model_grant(v, fl);
    er = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    check({tag, " fu_ready"}, 128'(fu_ready), 128'(er));
    @(posedge clk);
    model_edge(g);
    #1;
    check({tag, " cdb_valid"}, 128'(cdb_valid), 128'(m_valid));
    check({tag, " cdb_src"}, 128'(cdb_src), 128'(m_src));
    check({tag, " cdb_pkt"}, 128'(cdb_pkt), 128'(m_pkt));
  endtask

  initial begin
    int g;

    // Directed table, starting from pointer 0
    tbl[0]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2};  // single FU2 -> ptr 3
    tbl[1]  = '{4'b0011, 1'b0, 4'b0001, 1'b1, 2'd0};  // wrap past idle FU3
    tbl[2]  = '{4'b0011, 1'b0, 4'b0010, 1'b1, 2'd1};
    tbl[3]  = '{4'b1000, 1'b1, 4'b0000, 1'b0, 2'd1};  // flush: no grant, src holds
    tbl[4]  = '{4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3};  // pointer untouched by flush
    tbl[5]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3};
    for (int i = 0; i < 8; i++) begin
      tbl[6 + i] = '{4'b1111, 1'b0, 4'(4'b0001 << (i % 4)), 1'b1, 2'(i % 4)};
    end

    // Reset held with all FUs requesting
    model_reset();
    for (int i = 0; i < N; i++) fu_pkt[i] = rand_pkt();
    rst_n    = 1'b0;
    flush    = 1'b0;
    fu_valid = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    check("reset fu_ready", 128'(fu_ready), 128'(4'b0000));
    check("reset cdb_valid", 128'(cdb_valid), 128'(1'b0));
    check("reset cdb_src", 128'(cdb_src), 128'(2'd0));
    check("reset cdb_pkt", 128'(cdb_pkt), 128'(0));
    rst_n = 1'b1;
    apply(4'b1111, 1'b0, "first grant");

    // Reset mid-broadcast: valid drops without waiting for a clock
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async reset cdb_valid", 128'(cdb_valid), 128'(1'b0));
    check("async reset fu_ready", 128'(fu_ready), 128'(4'b0000));
    fu_valid = 4'b0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("async reset cdb_pkt", 128'(cdb_pkt), 128'(0));
    rst_n = 1'b1;

    // Table-driven directed vectors
    for (int i = 0; i < N; i++) fu_pkt[i] = rand_pkt();
    fu_pkt[2].value   = 32'hDEADBEEF;
    fu_pkt[2].rob_idx = 4'd5;
    for (int i = 0; i < 14; i++) begin
      fu_valid = tbl[i].valid;
      flush    = tbl[i].flush;
      #1;
      check($sformatf("tbl%0d fu_ready", i), 128'(fu_ready), 128'(tbl[i].ready));
      g = model_grant(tbl[i].valid, tbl[i].flush);
      @(posedge clk);
      model_edge(g);
      #1;
      check($sformatf("tbl%0d cdb_valid", i), 128'(cdb_valid), 128'(tbl[i].cvalid));
      check($sformatf("tbl%0d cdb_src", i), 128'(cdb_src), 128'(tbl[i].src));
      check($sformatf("tbl%0d cdb_pkt", i), 128'(cdb_pkt), 128'(m_pkt));
      if (i == 0) begin
        check("single value", 128'(cdb_pkt.value), 128'(32'hDEADBEEF));
        check("single rob_idx", 128'(cdb_pkt.rob_idx), 128'(4'd5));
      end
    end

    // Branch pass-through, dest_we=0 still broadcast for exactly one cycle
    fu_pkt[1]           = '0;
    fu_pkt[1].is_branch = 1'b1;
    fu_pkt[1].is_ctrl   = 1'b1;
    fu_pkt[1].br_taken  = 1'b1;
    fu_pkt[1].br_target = 32'h60000010;
    fu_pkt[1].dest_we   = 1'b0;
    fu_pkt[1].rob_idx   = 4'd9;
    apply(4'b0010, 1'b0, "branch");
    check("branch is_branch", 128'(cdb_pkt.is_branch), 128'(1'b1));
    check("branch br_taken", 128'(cdb_pkt.br_taken), 128'(1'b1));
    check("branch br_target", 128'(cdb_pkt.br_target), 128'(32'h60000010));
    check("branch dest_we", 128'(cdb_pkt.dest_we), 128'(1'b0));
    check("branch src", 128'(cdb_src), 128'(2'd1));
    apply(4'b0000, 1'b0, "branch idle");
    check("branch one-cycle pulse", 128'(cdb_valid), 128'(1'b0));

    // Randomized traffic with occasional flushes
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) fu_pkt[i] = rand_pkt();
      apply(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0), $sformatf("rand%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Completion-side counterpart of the functional units (ALU, MUL/DIV, LSU): accepts their registered result packets over the valid/ready response handshake and drives the single common data bus (CDB).
- One winner per cycle by round-robin; the winner's packet is registered and broadcast to the ROB, reservation stations, the physical register file and the branch-recovery logic.
- This block is the responder that drives each FU's resp_ready.

Parameters:
- NUM_FU, 4, number of requesting functional units (>=2; need not be a power of two).
- XLEN, 32, data width.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  mispredict flush; suppresses grant this cycle.
- fu_valid  input  NUM_FU  per-FU result-valid (FU resp_valid).
- fu_ready  output  NUM_FU  per-FU grant (drives FU resp_ready).
- fu_pkt  input  NUM_FU x cdb_pkt_t  per-FU result packet.
- cdb_valid  output  1  broadcast valid, single-cycle pulse per packet.
- cdb_pkt  output  cdb_pkt_t  broadcast packet.
- cdb_src  output  $clog2(NUM_FU)  index of the FU that produced cdb_pkt.

cdb_pkt_t fields:
- value[XLEN-1:0], rd[ARCH_REG_IDX:0], pd[PHYS_REG_IDX:0], rob_idx[$clog2(NUM_ROB_ENTRIES)-1:0]
- dest_we, br_taken, br_target[31:0], is_ctrl, is_branch, is_jalr

Behaviour:
- Reset (rst_n low, asynchronous):
  - cdb_valid=0, cdb_pkt='0, cdb_src=0, rr_ptr=0.
  - fu_ready=0 while rst_n is low.
- Grant (combinational from fu_valid, rr_ptr, flush):
  - Search indices rr_ptr, rr_ptr+1, ... modulo NUM_FU; the first i with fu_valid[i]=1 wins.
  - fu_ready[i]=1 for the winner only; fu_ready is one-hot or zero.
  - No path from fu_ready back into the grant. FU valids are registered, so the FU-side combinational req_ready loop stays acyclic.
- flush=1: fu_ready=0 for all FUs. Next cycle cdb_valid=0. rr_ptr is held. FUs clear their own pending results on flush.
- Transfer happens on fu_valid[i] && fu_ready[i]. Next edge:
  - cdb_valid<=1, cdb_pkt<=fu_pkt[i], cdb_src<=i.
  - rr_ptr<=(i+1) mod NUM_FU; wrap from NUM_FU-1 to 0.
- No transfer (no valid, or flush): cdb_valid<=0. cdb_pkt and cdb_src hold their last values. rr_ptr holds.
- Latency and throughput:
  - Exactly 1 cycle from handshake to cdb_valid.
  - One packet per cycle sustained; the CDB has no backpressure.
- Fairness: a continuously valid FU is granted within NUM_FU cycles.
- Packet fields are passed through unmodified. dest_we=0 packets are still broadcast, because the ROB needs completion and branch info.
- Simultaneous events:
  - All FUs valid: exactly one grant per cycle, rotating in order rr_ptr, rr_ptr+1, ...
  - flush and fu_valid in the same cycle: flush wins and no FU is dequeued.
- Reset asserted mid-broadcast: cdb_valid drops immediately (asynchronously). No packet is replayed after reset.
- Assertions:
  - fu_ready is one-hot-or-zero.
  - fu_ready[i] implies fu_valid[i].
  - cdb_valid is never 1 in the cycle after flush.

Decomposition:
- Shared package rv32i_types holds:
  - cdb_pkt_t (packed struct above).
  - NUM_FU_CDB default constant.
  - Reuse of existing ARCH_REG_IDX, PHYS_REG_IDX, NUM_ROB_ENTRIES.
- Sub-module rr_arbiter (parameter N): inputs req[N], ptr, enable; outputs one-hot gnt[N] and gnt_idx.
  - Combinational only.
  - The pointer register lives in cdb_arbiter.

Test Plan:
- Reset: hold rst_n=0 with fu_valid=4'b1111 -> fu_ready=0, cdb_valid=0. Release rst_n -> first grant goes to FU0; next cycle cdb_valid=1, cdb_src=0.
- Single FU: fu_valid=4'b0100, fu_pkt[2].value=32'hDEADBEEF, rob_idx=5 -> fu_ready=4'b0100 same cycle. Next cycle cdb_valid=1, cdb_pkt.value=32'hDEADBEEF, rob_idx=5, cdb_src=2; rr_ptr=3.
- Full contention: all four valid for 8 cycles, rr_ptr=0 at start -> grant order 0,1,2,3,0,1,2,3 and cdb_src follows one cycle later.
- Wrap: rr_ptr=3, fu_valid=4'b0011 -> FU0 granted, then FU1. FU3 idle does not stall the rotation.
- Flush: fu_valid=4'b1000 with flush=1 for one cycle -> fu_ready=0 and cdb_valid=0 next cycle. Flush drops -> FU3 granted; rr_ptr was unchanged during the flush.
- Branch pass-through: FU1 packet is_branch=1, br_taken=1, br_target=32'h60000010, dest_we=0 -> cdb_pkt carries identical fields and cdb_valid=1 for exactly one cycle.
